// File: rtl/ex_mdu.sv
// ex_mdu: iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
// Shift-add multiplier and restoring divider, one bit per cycle over 32
// CALC cycles, followed by a FIX cycle for sign correction and result select.
// Divide-by-zero and signed overflow take a single-cycle fast path.
// Optional feature macro: MDU_FAST_MUL_EN -- multiplies use one combinational
// 33x33 signed multiplier and complete with fast-path timing.
module ex_mdu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mdu_start,
   input  logic [2:0]  mdu_funct,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic        flush,
   output logic        mdu_stall,
   output logic        mdu_done,
   output logic [31:0] mdu_result
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic [2:0]  funct_q;
   // multiply: full product / multiplier shifting out of [31:0]
   // divide:   [31:0] holds dividend shifting out, quotient shifting in
   logic [63:0] acc;
   logic [31:0] rem_q;     // divide partial remainder (always < divisor)
   logic [31:0] opnd;      // multiplicand or divisor magnitude
   logic        neg_q;     // product / quotient must be negated in FIX
   logic        neg_r;     // remainder must be negated in FIX

   // ---------------- decode of the incoming operation ----------------
   logic        is_div, sgn_a, sgn_b, a_neg, b_neg;
   logic [31:0] a_abs, b_abs;
   logic        div0, ovf, fast_mul, fast, accept;
   logic [31:0] mul_res, fast_res;

   assign is_div = mdu_funct[2];
   // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM
   assign sgn_a  = (mdu_funct == 3'b001) || (mdu_funct == 3'b010) ||
                   (mdu_funct == 3'b100) || (mdu_funct == 3'b110);
   assign sgn_b  = (mdu_funct == 3'b001) || (mdu_funct == 3'b100) ||
                   (mdu_funct == 3'b110);
   assign a_neg  = sgn_a & rs1_data[31];
   assign b_neg  = sgn_b & rs2_data[31];
   assign a_abs  = a_neg ? (32'd0 - rs1_data) : rs1_data;
   assign b_abs  = b_neg ? (32'd0 - rs2_data) : rs2_data;

   assign div0   = is_div && (rs2_data == 32'd0);
   // signed overflow only exists for DIV/REM (funct[0] clear)
   assign ovf    = is_div && !mdu_funct[0] && (rs1_data == 32'h8000_0000) &&
                   (rs2_data == 32'hFFFF_FFFF);

`ifdef MDU_FAST_MUL_EN
   // 33x33 signed product: each operand is sign- or zero-extended, so the low
   // 64 bits of a 64-bit product are exact for every multiply variant
   logic [63:0] fm_a, fm_b, fm_p;
   assign fm_a     = {{32{a_neg}}, rs1_data};
   assign fm_b     = {{32{b_neg}}, rs2_data};
   assign fm_p     = fm_a * fm_b;
   assign fast_mul = !is_div;
   assign mul_res  = (mdu_funct[1:0] == 2'b00) ? fm_p[31:0] : fm_p[63:32];
`else
   assign fast_mul = 1'b0;
   assign mul_res  = 32'd0;
`endif

   assign fast   = div0 || ovf || fast_mul;
   assign accept = (state == IDLE) && mdu_start && !flush;

   // result for operations finishing at the accept edge
   always_comb begin
      fast_res = mul_res;
      if (div0)
         fast_res = mdu_funct[1] ? rs1_data : 32'hFFFF_FFFF;
      else if (ovf)
         fast_res = mdu_funct[1] ? 32'd0 : 32'h8000_0000;
   end

   // stall covers the accept cycle too so EX holds until DONE
   assign mdu_stall = (state == CALC) || (state == FIX) || accept;

   // ---------------- one iteration step ----------------
   logic [32:0] mul_sum;
   logic [32:0] pr;        // shifted partial remainder
   logic        ge;
   logic [31:0] dsub;

   assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
   assign pr      = {rem_q, acc[31]};
   assign ge      = (pr >= {1'b0, opnd});
   // when ge holds the true difference is below the divisor, so 32 bits suffice
   assign dsub    = pr[31:0] - opnd;

   // ---------------- sign correction and result select ----------------
   logic [63:0] pneg;
   logic [31:0] qv, rv, fix_res;

   // sign-correct the product, quotient and remainder, then pick by funct
   always_comb begin
      pneg = neg_q ? (64'd0 - acc) : acc;
      qv   = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
      rv   = neg_r ? (32'd0 - rem_q) : rem_q;
      case (funct_q)
         3'b000:                 fix_res = pneg[31:0];
         3'b001, 3'b010, 3'b011: fix_res = pneg[63:32];
         3'b100, 3'b101:         fix_res = qv;
         default:                fix_res = rv;
      endcase
   end

   // sequencer: accept, iterate, fix up, present result; flush aborts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= 5'd0;
         funct_q    <= 3'd0;
         acc        <= 64'd0;
         rem_q      <= 32'd0;
         opnd       <= 32'd0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         mdu_done   <= 1'b0;
         mdu_result <= 32'd0;
      end else if (flush) begin
         state    <= IDLE;
         cnt      <= 5'd0;
         mdu_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               mdu_done <= 1'b0;
               if (accept) begin
                  funct_q <= mdu_funct;
                  cnt     <= 5'd0;
                  neg_q   <= a_neg ^ b_neg;
                  neg_r   <= a_neg;
                  if (fast) begin
                     mdu_result <= fast_res;
                     mdu_done   <= 1'b1;
                     state      <= DONE;
                  end else begin
                     rem_q <= 32'd0;
                     if (is_div) begin
                        acc  <= {32'd0, a_abs};
                        opnd <= b_abs;
                     end else begin
                        acc  <= {32'd0, b_abs};
                        opnd <= a_abs;
                     end
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (funct_q[2]) begin
                  acc   <= {acc[63:32], acc[30:0], ge};
                  rem_q <= ge ? dsub : pr[31:0];
               end else begin
                  acc   <= {mul_sum, acc[31:1]};
               end
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31)
                  state <= FIX;
            end
            FIX: begin
               mdu_result <= fix_res;
               mdu_done   <= 1'b1;
               state      <= DONE;
            end
            default: begin
               mdu_done <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed vector table for ex_mdu plus hand-written flush,
// flush-with-start and mid-operation reset sequences.
module tb_ex_mdu;

   logic        clk;
   logic        rst_n;
   logic        mdu_start;
   logic [2:0]  mdu_funct;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        flush;
   logic        mdu_stall;
   logic        mdu_done;
   logic [31:0] mdu_result;

`ifdef MDU_FAST_MUL_EN
   localparam bit FASTMUL = 1'b1;
`else
   localparam bit FASTMUL = 1'b0;
`endif

   ex_mdu dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mdu_start  (mdu_start),
      .mdu_funct  (mdu_funct),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .flush      (flush),
      .mdu_stall  (mdu_stall),
      .mdu_done   (mdu_done),
      .mdu_result (mdu_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      bit          fast;   // special-case fast path
   } vec_t;

   localparam int NV = 14;
   vec_t vt[NV];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", nm, got, exp);
      end
   endtask

   task automatic set_vec(input int i, input string nm, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit fast);
      vt[i].nm = nm; vt[i].f = f; vt[i].a = a; vt[i].b = b;
      vt[i].exp = exp; vt[i].fast = fast;
   endtask

   // issue one op from an IDLE cycle; lat = cycles from accept to done pulse
   // (0 if it never came), stl = cycles with stall high including accept cycle
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int stl, output logic [31:0] res);
      @(negedge clk);
      mdu_start = 1'b1; mdu_funct = f; rs1_data = a; rs2_data = b;
      #1;
      stl = mdu_stall ? 1 : 0;
      lat = 0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); #1;
         if (mdu_stall) stl++;
         if (mdu_done) begin
            lat = i;
            break;
         end
      end
      mdu_start = 1'b0;
      res = mdu_result;
   endtask

   initial begin
      int          lat, stl, exp_lat, done_seen;
      logic [31:0] res, last;

      set_vec(0,  "mul",       3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
      set_vec(1,  "mulhu",     3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      set_vec(2,  "mulh",      3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
      set_vec(3,  "mulhsu",    3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0);
      set_vec(4,  "div",       3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
      set_vec(5,  "rem",       3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0);
      set_vec(6,  "divu",      3'b101, 32'd100,        32'd7,         32'd14,        1'b0);
      set_vec(7,  "remu",      3'b111, 32'd100,        32'd7,         32'd2,         1'b0);
      set_vec(8,  "divu_by0",  3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1);
      set_vec(9,  "rem_by0",   3'b110, 32'd5,          32'd0,         32'd5,         1'b1);
      set_vec(10, "div_ovf",   3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      set_vec(11, "rem_ovf",   3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1);
      set_vec(12, "div_by0",   3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1);
      set_vec(13, "remu_by0",  3'b111, 32'd7,          32'd0,         32'd7,         1'b1);

      rst_n = 1'b0; mdu_start = 1'b0; mdu_funct = 3'd0;
      rs1_data = 32'd0; rs2_data = 32'd0; flush = 1'b0;
      #12;
      chk("reset_stall",  {31'd0, mdu_stall}, 32'd0);
      chk("reset_done",   {31'd0, mdu_done},  32'd0);
      chk("reset_result", mdu_result,         32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         exp_lat = (vt[i].fast || (FASTMUL && !vt[i].f[2])) ? 1 : 34;
         run_op(vt[i].f, vt[i].a, vt[i].b, lat, stl, res);
         chk({vt[i].nm, "_result"}, res, vt[i].exp);
         chk({vt[i].nm, "_latency"}, lat, exp_lat);
         chk({vt[i].nm, "_stall_cycles"}, stl, exp_lat);
         @(posedge clk); #1;
         chk({vt[i].nm, "_done_pulse"}, {31'd0, mdu_done}, 32'd0);
      end
      last = vt[NV-1].exp;

      // flush at E+10 aborts a divide: no done, result untouched
      @(negedge clk);
      mdu_start = 1'b1; mdu_funct = 3'b100; rs1_data = 32'd100; rs2_data = 32'd7;
      @(posedge clk);               // accept edge E
      repeat (9) @(posedge clk);    // now in cycle E+10
      @(negedge clk);
      flush = 1'b1; mdu_start = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_stall",  {31'd0, mdu_stall}, 32'd0);
      chk("flush_result", mdu_result,         last);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (mdu_done) done_seen++;
      end
      chk("flush_no_done", done_seen, 32'd0);
      run_op(3'b101, 32'd9, 32'd3, lat, stl, res);
      chk("after_flush_divu", res, 32'd3);
      chk("after_flush_lat",  lat, 32'd34);
      @(posedge clk); #1;

      // start together with flush in IDLE is not accepted
      @(negedge clk);
      mdu_start = 1'b1; flush = 1'b1; mdu_funct = 3'b101; rs1_data = 32'd8; rs2_data = 32'd0;
      #1;
      chk("flush_start_stall", {31'd0, mdu_stall}, 32'd0);
      @(posedge clk); #1;
      mdu_start = 1'b0; flush = 1'b0;
      chk("flush_start_done",   {31'd0, mdu_done}, 32'd0);
      chk("flush_start_result", mdu_result,        32'd3);

      // reset at E+20 of a divide returns outputs to reset values at once
      @(negedge clk);
      mdu_start = 1'b1; mdu_funct = 3'b100; rs1_data = 32'd100; rs2_data = 32'd7;
      @(posedge clk);
      repeat (19) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0; mdu_start = 1'b0;
      #1;
      chk("midreset_stall",  {31'd0, mdu_stall}, 32'd0);
      chk("midreset_done",   {31'd0, mdu_done},  32'd0);
      chk("midreset_result", mdu_result,         32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(3'b111, 32'd100, 32'd7, lat, stl, res);
      chk("after_reset_remu", res, 32'd2);
      chk("after_reset_lat",  lat, 32'd34);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
